// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, funct fields, ALU/immediate enums and the
// pipeline-register layouts passed between stages of riscv_pipe_cpu.
package riscv_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;
    localparam logic [2:0] F3_BEQ  = 3'd0;
    localparam logic [2:0] F3_BNE  = 3'd1;
    localparam logic [2:0] F3_BLT  = 3'd4;
    localparam logic [2:0] F3_BGE  = 3'd5;
    localparam logic [2:0] F3_BLTU = 3'd6;
    localparam logic [2:0] F3_BGEU = 3'd7;
    localparam logic [2:0] F3_WORD = 3'd2;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } aluOpT;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} immTypeT;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } ifIdT;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] rs1Val;
        logic [31:0] rs2Val;
        logic [31:0] imm;
        aluOpT       aluOp;
        logic [2:0]  funct3;
        logic        srcAPc;
        logic        srcBImm;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic        isBranch;
        logic        isJal;
        logic        isJalr;
    } idExT;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        regWrite;
        logic        memRead;
        logic        memWrite;
        logic [31:0] result;
        logic [31:0] storeData;
    } exMemT;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic        regWrite;
        logic [31:0] value;
    } memWbT;

    function automatic logic [31:0] immGen(input logic [31:0] instr, input immTypeT kind);
        case (kind)
            IMM_S:   return {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   return {instr[31:12], 12'b0};
            IMM_J:   return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: return {{20{instr[31]}}, instr[31:20]};
        endcase
    endfunction

endpackage

// File: rtl/instr_mem.sv
// Word-addressed instruction ROM with combinational read; contents are loaded
// from outside and default to NOPs so an unloaded location is harmless.
module instr_mem
    import riscv_pkg::*;
#(
    parameter int WORDS = 1024
) (
    input  logic [$clog2(WORDS)-1:0] wordAddr,
    output logic [31:0]              data
);

    logic [31:0] RAM [0:WORDS-1] = '{default: NOP_INSTR};

    assign data = RAM[wordAddr];

endmodule

// File: rtl/riscv_pipe_cpu.sv
// Five-stage in-order RV32I core with EX-stage branch resolution, full
// forwarding into EX and a one-cycle load-use interlock.
module riscv_pipe_cpu
    import riscv_pkg::*;
#(
    parameter int IMEM_WORDS = 1024,
    parameter int DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc
);

    localparam int IAW = $clog2(IMEM_WORDS);
    localparam int DAW = $clog2(DMEM_WORDS);

    ifIdT  ifId;
    idExT  idEx, idNext;
    exMemT exMem, exNext;
    memWbT memWb, wbNext;

    logic [31:0] regs [0:31];
    logic [31:0] dataMem [0:DMEM_WORDS-1] = '{default: '0};

    logic [31:0] fetchInstr, rs1Val, rs2Val, loadData;
    logic [31:0] fwdA, fwdB, opA, opB, aluOut, target;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rs1, rs2;
    logic        useRs1, useRs2, stall, redirect, branchTaken;
    immTypeT     immType;

    instr_mem #(.WORDS(IMEM_WORDS)) instrMem (
        .wordAddr(pc[2 +: IAW]),
        .data    (fetchInstr)
    );

    assign opcode = ifId.instr[6:0];
    assign funct7 = ifId.instr[31:25];
    assign rs1    = ifId.instr[19:15];
    assign rs2    = ifId.instr[24:20];

    // Register read with WB bypass so a same-cycle write is seen by ID.
    assign rs1Val = (rs1 == 5'd0) ? 32'd0 :
                    (memWb.valid && memWb.regWrite && memWb.rd == rs1) ? memWb.value : regs[rs1];
    assign rs2Val = (rs2 == 5'd0) ? 32'd0 :
                    (memWb.valid && memWb.regWrite && memWb.rd == rs2) ? memWb.value : regs[rs2];

    always_comb begin
        idNext        = '0;
        immType       = IMM_I;
        useRs1        = 1'b0;
        useRs2        = 1'b0;
        idNext.valid  = ifId.valid;
        idNext.pc     = ifId.pc;
        idNext.rs1    = rs1;
        idNext.rs2    = rs2;
        idNext.rd     = ifId.instr[11:7];
        idNext.funct3 = ifId.instr[14:12];
        idNext.aluOp  = ALU_ADD;
        if (ifId.valid) begin
            case (opcode)
                OP_LUI:   begin idNext.regWrite = 1'b1; idNext.srcBImm = 1'b1; idNext.aluOp = ALU_PASSB; immType = IMM_U; end
                OP_AUIPC: begin idNext.regWrite = 1'b1; idNext.srcAPc = 1'b1; idNext.srcBImm = 1'b1; immType = IMM_U; end
                OP_JAL:   begin idNext.regWrite = 1'b1; idNext.isJal = 1'b1; immType = IMM_J; end
                OP_JALR:  if (idNext.funct3 == F3_ADD) begin
                              idNext.regWrite = 1'b1; idNext.isJalr = 1'b1; useRs1 = 1'b1;
                          end
                OP_BRANCH: if (idNext.funct3 != 3'd2 && idNext.funct3 != 3'd3) begin
                              idNext.isBranch = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; immType = IMM_B;
                          end
                OP_LOAD:  if (idNext.funct3 == F3_WORD) begin
                              idNext.regWrite = 1'b1; idNext.memRead = 1'b1; idNext.srcBImm = 1'b1; useRs1 = 1'b1;
                          end
                OP_STORE: if (idNext.funct3 == F3_WORD) begin
                              idNext.memWrite = 1'b1; idNext.srcBImm = 1'b1; useRs1 = 1'b1; useRs2 = 1'b1; immType = IMM_S;
                          end
                OP_IMM: begin
                    idNext.regWrite = 1'b1;
                    idNext.srcBImm  = 1'b1;
                    useRs1          = 1'b1;
                    case (idNext.funct3)
                        F3_SLT:  idNext.aluOp = ALU_SLT;
                        F3_SLTU: idNext.aluOp = ALU_SLTU;
                        F3_XOR:  idNext.aluOp = ALU_XOR;
                        F3_OR:   idNext.aluOp = ALU_OR;
                        F3_AND:  idNext.aluOp = ALU_AND;
                        F3_SLL:  if (funct7 == F7_BASE) idNext.aluOp = ALU_SLL; else idNext.regWrite = 1'b0;
                        F3_SR:   if (funct7 == F7_BASE) idNext.aluOp = ALU_SRL;
                                 else if (funct7 == F7_ALT) idNext.aluOp = ALU_SRA;
                                 else idNext.regWrite = 1'b0;
                        default: idNext.aluOp = ALU_ADD;
                    endcase
                end
                OP_REG: begin
                    idNext.regWrite = 1'b1;
                    useRs1          = 1'b1;
                    useRs2          = 1'b1;
                    case ({funct7, idNext.funct3})
                        {F7_BASE, F3_ADD}:  idNext.aluOp = ALU_ADD;
                        {F7_ALT,  F3_ADD}:  idNext.aluOp = ALU_SUB;
                        {F7_BASE, F3_SLL}:  idNext.aluOp = ALU_SLL;
                        {F7_BASE, F3_SLT}:  idNext.aluOp = ALU_SLT;
                        {F7_BASE, F3_SLTU}: idNext.aluOp = ALU_SLTU;
                        {F7_BASE, F3_XOR}:  idNext.aluOp = ALU_XOR;
                        {F7_BASE, F3_SR}:   idNext.aluOp = ALU_SRL;
                        {F7_ALT,  F3_SR}:   idNext.aluOp = ALU_SRA;
                        {F7_BASE, F3_OR}:   idNext.aluOp = ALU_OR;
                        {F7_BASE, F3_AND}:  idNext.aluOp = ALU_AND;
                        default:            idNext.regWrite = 1'b0;
                    endcase
                end
                default: idNext.regWrite = 1'b0;
            endcase
        end
        idNext.imm    = immGen(ifId.instr, immType);
        idNext.rs1Val = rs1Val;
        idNext.rs2Val = rs2Val;
    end

    assign stall = idEx.valid && idEx.memRead && idEx.rd != 5'd0 &&
                   ((useRs1 && idEx.rd == rs1) || (useRs2 && idEx.rd == rs2));

    // EX: forwarding, ALU, branch resolution; EX/MEM wins over MEM/WB.
    always_comb begin
        fwdA = idEx.rs1Val;
        if (exMem.valid && exMem.regWrite && exMem.rd != 5'd0 && exMem.rd == idEx.rs1)
            fwdA = exMem.result;
        else if (memWb.valid && memWb.regWrite && memWb.rd != 5'd0 && memWb.rd == idEx.rs1)
            fwdA = memWb.value;
        fwdB = idEx.rs2Val;
        if (exMem.valid && exMem.regWrite && exMem.rd != 5'd0 && exMem.rd == idEx.rs2)
            fwdB = exMem.result;
        else if (memWb.valid && memWb.regWrite && memWb.rd != 5'd0 && memWb.rd == idEx.rs2)
            fwdB = memWb.value;

        opA = idEx.srcAPc  ? idEx.pc  : fwdA;
        opB = idEx.srcBImm ? idEx.imm : fwdB;
        case (idEx.aluOp)
            ALU_SUB:   aluOut = opA - opB;
            ALU_SLL:   aluOut = opA << opB[4:0];
            ALU_SLT:   aluOut = {31'd0, $signed(opA) < $signed(opB)};
            ALU_SLTU:  aluOut = {31'd0, opA < opB};
            ALU_XOR:   aluOut = opA ^ opB;
            ALU_SRL:   aluOut = opA >> opB[4:0];
            ALU_SRA:   aluOut = $unsigned($signed(opA) >>> opB[4:0]);
            ALU_OR:    aluOut = opA | opB;
            ALU_AND:   aluOut = opA & opB;
            ALU_PASSB: aluOut = opB;
            default:   aluOut = opA + opB;
        endcase

        case (idEx.funct3)
            F3_BEQ:  branchTaken = (fwdA == fwdB);
            F3_BNE:  branchTaken = (fwdA != fwdB);
            F3_BLT:  branchTaken = ($signed(fwdA) < $signed(fwdB));
            F3_BGE:  branchTaken = ($signed(fwdA) >= $signed(fwdB));
            F3_BLTU: branchTaken = (fwdA < fwdB);
            F3_BGEU: branchTaken = (fwdA >= fwdB);
            default: branchTaken = 1'b0;
        endcase

        redirect = idEx.valid && (idEx.isJal || idEx.isJalr || (idEx.isBranch && branchTaken));
        target   = idEx.isJalr ? ((fwdA + idEx.imm) & ~32'd1) : (idEx.pc + idEx.imm);

        exNext           = '0;
        exNext.valid     = idEx.valid;
        exNext.rd        = idEx.rd;
        exNext.regWrite  = idEx.regWrite;
        exNext.memRead   = idEx.memRead;
        exNext.memWrite  = idEx.memWrite;
        exNext.result    = (idEx.isJal || idEx.isJalr) ? idEx.pc + 32'd4 : aluOut;
        exNext.storeData = fwdB;
    end

    assign loadData = dataMem[exMem.result[2 +: DAW]];

    always_comb begin
        wbNext          = '0;
        wbNext.valid    = exMem.valid;
        wbNext.rd       = exMem.rd;
        wbNext.regWrite = exMem.regWrite;
        wbNext.value    = exMem.memRead ? loadData : exMem.result;
    end

    always_ff @(posedge clk) begin
        if (exMem.valid && exMem.memWrite)
            dataMem[exMem.result[2 +: DAW]] <= exMem.storeData;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (memWb.valid && memWb.regWrite && memWb.rd != 5'd0) begin
            regs[memWb.rd] <= memWb.value;
        end
    end

    // A redirect flushes the younger stages and overrides any pending stall.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc    <= '0;
            ifId  <= '0;
            idEx  <= '0;
            exMem <= '0;
            memWb <= '0;
        end else begin
            exMem <= exNext;
            memWb <= wbNext;
            if (redirect) begin
                pc   <= target;
                ifId <= '0;
                idEx <= '0;
            end else if (stall) begin
                idEx <= '0;
            end else begin
                pc         <= pc + 32'd4;
                ifId.valid <= 1'b1;
                ifId.pc    <= pc;
                ifId.instr <= fetchInstr;
                idEx       <= idNext;
            end
        end
    end

endmodule

// File: tb/tb_riscv_pipe_cpu.sv
// Directed bench for riscv_pipe_cpu: loads small programs into instrMem and
// scores PC traces and architectural state against a queue of expectations.
module tb_riscv_pipe_cpu;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] pc;

    int errors = 0;
    int checks = 0;

    logic [31:0] expQ[$];
    string       tagQ[$];
    logic [31:0] prog[$];
    logic [31:0] pcTrace[$];

    riscv_pipe_cpu #(.IMEM_WORDS(1024), .DMEM_WORDS(1024)) dut (
        .clk  (clk),
        .reset(reset),
        .pc   (pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=still running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] encI(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [31:0] imm);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] encR(input logic [6:0] f7, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] encS(input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] encB(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] encJ(input logic [4:0] rd, input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
    endfunction

    function automatic logic [31:0] encU(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] imm);
        return {imm[31:12], rd, op};
    endfunction

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic pushExpected(input string tag, input logic [31:0] value);
        expQ.push_back(value);
        tagQ.push_back(tag);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        logic [31:0] expected;
        string       tag;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=%h required=an expectation", observed);
            return;
        end
        expected = expQ.pop_front();
        tag      = tagQ.pop_front();
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic pushPcTrace(input string prefix);
        foreach (pcTrace[i]) pushExpected($sformatf("%s_pc%0d", prefix, i), pcTrace[i]);
    endtask

    task automatic checkPcTrace(input int samples);
        repeat (samples) begin
            checkOutput(pc);
            applyStimulus(1);
        end
    endtask

    // Holds reset while the program is written, then releases on a falling edge.
    task automatic loadProgram();
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.instrMem.RAM[i] = NOP;
        foreach (prog[i]) dut.instrMem.RAM[i] = prog[i];
        applyStimulus(1);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        pushExpected("reset_pc", 32'h0);
        pushExpected("reset_x1", 32'h0);
        checkOutput(pc);
        checkOutput(dut.regs[1]);

        // ADDI chain with back-to-back forwarding
        prog = {encI(7'h13, 3'd0, 5'd1, 5'd0, 32'd5),
                encI(7'h13, 3'd0, 5'd2, 5'd1, 32'd3),
                encR(7'h00, 3'd0, 5'd3, 5'd1, 5'd2)};
        loadProgram();
        pcTrace = {32'h0, 32'h4, 32'h8, 32'hC};
        pushPcTrace("chain");
        checkPcTrace(4);
        applyStimulus(6);
        pushExpected("chain_x1", 32'd5);
        pushExpected("chain_x2", 32'd8);
        pushExpected("chain_x3", 32'd13);
        checkOutput(dut.regs[1]);
        checkOutput(dut.regs[2]);
        checkOutput(dut.regs[3]);

        // Store, then load-use dependency forcing a single stall
        prog = {encU(7'h37, 5'd7, 32'h0000_1000),
                encI(7'h13, 3'd0, 5'd7, 5'd7, 32'h234),
                encS(5'd0, 5'd7, 32'd16),
                encI(7'h03, 3'd2, 5'd5, 5'd0, 32'd16),
                encI(7'h13, 3'd0, 5'd6, 5'd5, 32'd1)};
        loadProgram();
        pcTrace = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd20, 32'd24, 32'd28};
        pushPcTrace("loaduse");
        checkPcTrace(9);
        applyStimulus(6);
        pushExpected("loaduse_mem", 32'h1234);
        pushExpected("loaduse_x5", 32'h1234);
        pushExpected("loaduse_x6", 32'h1235);
        checkOutput(dut.dataMem[4]);
        checkOutput(dut.regs[5]);
        checkOutput(dut.regs[6]);

        // Shifts, compares, x0 write and no forwarding from x0
        prog = {encU(7'h37, 5'd1, 32'h8000_0000),
                encI(7'h13, 3'd5, 5'd2, 5'd1, 32'h404),
                encI(7'h13, 3'd0, 5'd3, 5'd0, 32'hFFF),
                encI(7'h13, 3'd0, 5'd4, 5'd0, 32'd1),
                encR(7'h00, 3'd2, 5'd5, 5'd3, 5'd4),
                encR(7'h00, 3'd3, 5'd6, 5'd3, 5'd4),
                encI(7'h13, 3'd0, 5'd0, 5'd0, 32'd5),
                encR(7'h00, 3'd0, 5'd14, 5'd0, 5'd4),
                encR(7'h20, 3'd0, 5'd7, 5'd4, 5'd3),
                encR(7'h00, 3'd4, 5'd8, 5'd3, 5'd4),
                encR(7'h00, 3'd5, 5'd9, 5'd1, 5'd4),
                encI(7'h13, 3'd3, 5'd10, 5'd4, 32'hFFF),
                encR(7'h20, 3'd5, 5'd11, 5'd1, 5'd4)};
        loadProgram();
        applyStimulus(20);
        pushExpected("srai", 32'hF800_0000);
        pushExpected("slt", 32'd1);
        pushExpected("sltu", 32'd0);
        pushExpected("x0", 32'd0);
        pushExpected("add_x0_src", 32'd1);
        pushExpected("sub", 32'd2);
        pushExpected("xor", 32'hFFFF_FFFE);
        pushExpected("srl", 32'h4000_0000);
        pushExpected("sltiu", 32'd1);
        pushExpected("sra", 32'hC000_0000);
        checkOutput(dut.regs[2]);
        checkOutput(dut.regs[5]);
        checkOutput(dut.regs[6]);
        checkOutput(dut.regs[0]);
        checkOutput(dut.regs[14]);
        checkOutput(dut.regs[7]);
        checkOutput(dut.regs[8]);
        checkOutput(dut.regs[9]);
        checkOutput(dut.regs[10]);
        checkOutput(dut.regs[11]);

        // Branches, JAL/JALR loop, then async reset in the middle of the loop
        prog = {encI(7'h13, 3'd0, 5'd1, 5'd0, 32'd1),
                encB(3'd0, 5'd1, 5'd1, 32'd12),
                encI(7'h13, 3'd0, 5'd10, 5'd0, 32'd7),
                encI(7'h13, 3'd0, 5'd11, 5'd0, 32'd7),
                encI(7'h13, 3'd0, 5'd12, 5'd0, 32'd9),
                encI(7'h13, 3'd0, 5'd2, 5'd0, 32'hFFF),
                encB(3'd6, 5'd2, 5'd1, 32'd8),
                encI(7'h13, 3'd0, 5'd13, 5'd0, 32'd5),
                encJ(5'd1, 32'd8),
                encI(7'h13, 3'd0, 5'd14, 5'd14, 32'd1),
                encI(7'h67, 3'd0, 5'd0, 5'd1, 32'd0)};
        loadProgram();
        pcTrace = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16, 32'd20, 32'd24, 32'd28, 32'd32, 32'd36,
                   32'd40, 32'd40, 32'd44, 32'd48, 32'd36, 32'd40, 32'd44, 32'd48, 32'd36};
        pushPcTrace("ctrl");
        checkPcTrace(19);
        applyStimulus(11);
        pushExpected("flushed_x10", 32'd0);
        pushExpected("flushed_x11", 32'd0);
        pushExpected("beq_target_x12", 32'd9);
        pushExpected("bltu_fallthru_x13", 32'd5);
        pushExpected("jal_link_x1", 32'h24);
        pushExpected("loop_count_x14", 32'd3);
        checkOutput(dut.regs[10]);
        checkOutput(dut.regs[11]);
        checkOutput(dut.regs[12]);
        checkOutput(dut.regs[13]);
        checkOutput(dut.regs[1]);
        checkOutput(dut.regs[14]);

        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        pushExpected("midrun_reset_pc", 32'h0);
        pushExpected("midrun_reset_x14", 32'h0);
        pushExpected("midrun_reset_x1", 32'h0);
        checkOutput(pc);
        checkOutput(dut.regs[14]);
        checkOutput(dut.regs[1]);
        applyStimulus(1);
        reset = 1'b0;
        pcTrace = {32'd0, 32'd4, 32'd8, 32'd12, 32'd16};
        pushPcTrace("rerun");
        checkPcTrace(5);
        applyStimulus(15);
        pushExpected("rerun_x12", 32'd9);
        pushExpected("rerun_x10", 32'd0);
        pushExpected("rerun_x1", 32'h24);
        pushExpected("rerun_mem_kept", 32'h1234);
        checkOutput(dut.regs[12]);
        checkOutput(dut.regs[10]);
        checkOutput(dut.regs[1]);
        checkOutput(dut.dataMem[4]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
